display_arbiter: RTL and testbench

- Shares the 4-digit multiplexed 7-segment display between up to NUM_REQ independent sources, e.g. operand entry, adder result and status/error codes.
- Grants ownership round-robin, with a minimum hold time so each view stays readable.
- Drives the 16-bit BCD word consumed by the display multiplexer.
- Sits between the datapath producers and the display driver.

---
 rtl/display_arbiter.sv | 144 ++++++++++++++
 tb/tb_display_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 4-digit BCD display with a minimum hold time per grant.
// Optional build macro DISPLAY_LEADING_BLANK_EN blanks leading zero digits of the captured word.
module display_arbiter #(
  parameter int          NUM_REQ     = 3,
  parameter int          HOLD_CYCLES = 27000000,
  parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [16*NUM_REQ-1:0]      data_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       busy_o,
  output logic [15:0]                bcd_o
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]      HOLD_INIT = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [OW-1:0]       owner_q;
  logic [OW-1:0]       ptr_q;
  logic                busy_q;
  logic [15:0]         bcd_q;
  logic [CW-1:0]       cnt_q;

  logic [15:0]         word [NUM_REQ];
  logic [NUM_REQ-1:0]  cand_mask;
  logic [OW:0]         pick;
  logic [OW-1:0]       win_idx;
  logic                grant_now;

  // First set bit of mask at or above ptr, wrapping; MSB of result flags a hit.
  function automatic logic [OW:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                          input logic [OW-1:0] ptr);
    logic [OW:0]   res;
    logic [OW-1:0] idx_v;
    int            idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx + 0;
      end
      idx_v = idx[OW-1:0];
      if (mask[idx_v]) begin
        res = {1'b1, idx_v};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Leading-zero blanking stops at the first nonzero digit; digit 0 always shows.
  function automatic logic [15:0] shape(input logic [15:0] w);
    logic [15:0] r;
    r = w;
`ifdef DISPLAY_LEADING_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int n = 3; n >= 1; n--) begin
        if (lead && (w[4*n +: 4] == 4'h0)) begin
          r[4*n +: 4] = BLANK_CODE;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
    return r;
  endfunction

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_word
    assign word[k] = data_i[16*k +: 16];
  end

  // Candidate set for the next grant; the current owner never wins its own handoff.
  always_comb begin
    cand_mask = req_i;
    if (state_q == OWN) begin
      cand_mask[owner_q] = 1'b0;
    end else begin
      cand_mask = req_i;
    end
    pick      = rr_pick(cand_mask, ptr_q);
    win_idx   = pick[OW-1:0];
    grant_now = pick[OW] && ((state_q == IDLE) || (cnt_q == '0));
  end

  // Ownership FSM with registered grant, owner, busy and display word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      bcd_q   <= 16'hFFFF;
      cnt_q   <= '0;
    end else if (grant_now) begin
      state_q <= OWN;
      gnt_q   <= GNT_ONE << win_idx;
      owner_q <= win_idx;
      ptr_q   <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + OW'(1);
      busy_q  <= 1'b1;
      bcd_q   <= shape(word[win_idx]);
      cnt_q   <= HOLD_INIT;
    end else begin
      case (state_q)
        OWN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end
          if (req_i[owner_q]) begin
            bcd_q <= shape(word[owner_q]);
          end else if (cnt_q == '0) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        IDLE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;
  assign bcd_o   = bcd_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter (NUM_REQ=3, HOLD_CYCLES=4) against a grant-age reference model.
module tb_display_arbiter;

  localparam int N    = 3;
  localparam int HOLD = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  req_i;
  logic [16*N-1:0] data_i;
  logic [N-1:0]  gnt_o;
  logic [1:0]    owner_o;
  logic          busy_o;
  logic [15:0]   bcd_o;

  int passed = 0;
  int total  = 0;

  // Reference model: who owns the display, for how many cycles, and what it shows.
  bit          m_busy;
  int          m_owner;
  int          m_ptr;
  int          m_held;
  logic [15:0] m_bcd;

  always #5 clk_i = ~clk_i;

  display_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .BLANK_CODE(4'hF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt_o), .owner_o(owner_o), .busy_o(busy_o), .bcd_o(bcd_o)
  );

  function automatic logic [15:0] m_shape(input logic [15:0] w);
    logic [15:0] r;
    r = w;
`ifdef DISPLAY_LEADING_BLANK_EN
    for (int k = 3; k >= 1; k--) begin
      if (w[4*k +: 4] != 4'h0) break;
      r[4*k +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_held = 0; m_bcd = 16'hFFFF;
  endtask

  task automatic model_edge();
    int  w, c;
    bit  found;
    if (m_busy && m_held < HOLD) begin
      m_held++;
      if (req_i[m_owner]) m_bcd = m_shape(data_i[16*m_owner +: 16]);
    end else begin
      found = 1'b0; w = 0;
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (!found && req_i[c] && !(m_busy && c == m_owner)) begin
          found = 1'b1; w = c;
        end
      end
      if (found) begin
        m_busy = 1'b1; m_owner = w; m_ptr = (w + 1) % N; m_held = 1;
        m_bcd = m_shape(data_i[16*w +: 16]);
      end else if (m_busy && req_i[m_owner]) begin
        m_bcd = m_shape(data_i[16*m_owner +: 16]);
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  function automatic logic [21:0] exp_vec();
    logic [2:0] g;
    g = m_busy ? (3'b001 << m_owner) : 3'b000;
    return {g, 2'(m_owner), m_busy, m_bcd};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    req_i = '0;
    rst_i = 1'b0;
    #1;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_i = '0; data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if ({gnt_o, owner_o, busy_o, bcd_o} !== {3'b000, 2'b00, 1'b0, 16'hFFFF}) begin
      $display("FAIL reset_state: got %h required %h", {gnt_o, owner_o, busy_o, bcd_o}, {3'b000, 2'b00, 1'b0, 16'hFFFF});
    end else passed++;
    model_reset();
    @(negedge clk_i) rst_i = 1'b1;
    req_i = 3'b010; data_i = {$urandom, $urandom};
    tick();
    total++;
    if (gnt_o !== 3'b010) $display("FAIL pre_reset_grant: got %b required 010", gnt_o);
    else passed++;
    tick();
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    total++;
    if ({gnt_o, busy_o, bcd_o} !== {3'b000, 1'b0, 16'hFFFF}) begin
      $display("FAIL async_reset: got %h required %h", {gnt_o, busy_o, bcd_o}, {3'b000, 1'b0, 16'hFFFF});
    end else passed++;
    @(negedge clk_i) rst_i = 1'b1;
    req_i = 3'b110;
    tick();
    total++;
    if (gnt_o !== 3'b010) $display("FAIL pointer_after_reset: got %b required 010", gnt_o);
    else passed++;
  endtask

  task automatic test_single();
    logic [15:0] e42;
    e42 = m_shape(16'h0042);
    do_reset();
    req_i = 3'b001; data_i = '0; data_i[15:0] = 16'h1234;
    tick();
    total++;
    if ({gnt_o, owner_o, bcd_o} !== {3'b001, 2'b00, 16'h1234}) begin
      $display("FAIL single_grant: got %h required %h", {gnt_o, owner_o, bcd_o}, {3'b001, 2'b00, 16'h1234});
    end else passed++;
    data_i[15:0] = 16'h0042;
    tick();
    total++;
    if (bcd_o !== e42) $display("FAIL single_track: got %h required %h", bcd_o, e42);
    else passed++;
  endtask

  task automatic test_contention();
    logic [2:0] e;
    do_reset();
    req_i = 3'b111; data_i = {$urandom, $urandom};
    for (int i = 0; i < 13; i++) begin
      tick();
      e = 3'b001 << ((i / HOLD) % N);
      total++;
      if (gnt_o !== e) $display("FAIL contention_cycle%0d: got %b required %b", i, gnt_o, e);
      else passed++;
      total++;
      if ({gnt_o, owner_o, busy_o, bcd_o} !== exp_vec()) begin
        $display("FAIL contention_model%0d: got %h required %h", i, {gnt_o, owner_o, busy_o, bcd_o}, exp_vec());
      end else passed++;
      data_i = {$urandom, $urandom};
    end
  endtask

  task automatic test_early_release();
    logic [15:0] held;
    do_reset();
    req_i = 3'b001; data_i = {$urandom, $urandom};
    tick();
    held = m_shape(data_i[15:0]);
    req_i = 3'b000;
    for (int i = 0; i < HOLD - 1; i++) begin
      data_i = {$urandom, $urandom};
      tick();
      total++;
      if ({gnt_o, bcd_o} !== {3'b001, held}) begin
        $display("FAIL early_hold%0d: got %h required %h", i, {gnt_o, bcd_o}, {3'b001, held});
      end else passed++;
    end
    tick();
    total++;
    if ({gnt_o, busy_o, bcd_o} !== {3'b000, 1'b0, held}) begin
      $display("FAIL early_release: got %h required %h", {gnt_o, busy_o, bcd_o}, {3'b000, 1'b0, held});
    end else passed++;
  endtask

  task automatic test_handoff();
    do_reset();
    req_i = 3'b001; data_i = {$urandom, $urandom};
    repeat (HOLD) tick();
    req_i = 3'b010; data_i = {$urandom, $urandom};
    tick();
    total++;
    if ({gnt_o, busy_o, bcd_o} !== {3'b010, 1'b1, m_shape(data_i[31:16])}) begin
      $display("FAIL handoff: got %h required %h", {gnt_o, busy_o, bcd_o}, {3'b010, 1'b1, m_shape(data_i[31:16])});
    end else passed++;
  endtask

  task automatic test_blank();
    logic [15:0] w [3];
    logic [15:0] e [3];
    w[0] = 16'h0042; w[1] = 16'h0000; w[2] = 16'h1004;
`ifdef DISPLAY_LEADING_BLANK_EN
    e[0] = 16'hFF42; e[1] = 16'hFFF0; e[2] = 16'h1004;
`else
    e[0] = 16'h0042; e[1] = 16'h0000; e[2] = 16'h1004;
`endif
    do_reset();
    req_i = 3'b001; data_i = '0;
    for (int i = 0; i < 3; i++) begin
      data_i[15:0] = w[i];
      tick();
      total++;
      if (bcd_o !== e[i]) $display("FAIL blank_%h: got %h required %h", w[i], bcd_o, e[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) req_i[b] = ~req_i[b];
      end
      data_i = {$urandom, $urandom};
      tick();
      total++;
      if ({gnt_o, owner_o, busy_o, bcd_o} !== exp_vec()) begin
        $display("FAIL random%0d: got %h required %h", i, {gnt_o, owner_o, busy_o, bcd_o}, exp_vec());
      end else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_handoff();
    test_blank();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
